// File: rtl/nap_pkg.sv
// Shared types, BCD limits and time helpers for the Power Honey Nap countdown.
package nap_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    ALARM = 3'd4
  } state_t;

  localparam int unsigned BCD_W = 4;

  localparam logic [BCD_W-1:0] SEC_UNIT_MAX = 4'd9;
  localparam logic [BCD_W-1:0] SEC_TEN_MAX  = 4'd5;
  localparam logic [BCD_W-1:0] MIN_MAX      = 4'd9;

  typedef struct packed {
    logic [BCD_W-1:0] one_min;
    logic [BCD_W-1:0] ten_sec;
    logic [BCD_W-1:0] one_sec;
  } bcd_time_t;

  localparam bcd_time_t ZERO_TIME   = '0;
  localparam bcd_time_t SNOOZE_TIME = 12'h100;

  function automatic logic bcd_valid(input bcd_time_t t);
    return (t.one_sec <= SEC_UNIT_MAX) && (t.ten_sec <= SEC_TEN_MAX) &&
           (t.one_min <= MIN_MAX) && (t != ZERO_TIME);
  endfunction

  // One-second decrement with the M:SS borrow chain; caller never passes 0:00.
  function automatic bcd_time_t bcd_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.one_sec != 4'd0) begin
      r.one_sec = t.one_sec - 4'd1;
    end else begin
      r.one_sec = SEC_UNIT_MAX;
      if (t.ten_sec != 4'd0) begin
        r.ten_sec = t.ten_sec - 4'd1;
      end else begin
        r.ten_sec = SEC_TEN_MAX;
        r.one_min = t.one_min - 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/nap_tick_gen.sv
// One-second prescaler: counts 0..TICK_DIV-1 while enabled, tick on the terminal count.
module nap_tick_gen
  import nap_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == CNT_MAX) ? '0 : count + CNT_W'(1);
    end
  end

  assign tick = en && (count == CNT_MAX);

endmodule

// File: rtl/nap_countdown_ctrl.sv
// Nap countdown sequencer: load/validate, BCD countdown, pause/resume, alarm.
// Optional snooze from ALARM is built when NAP_SNOOZE_EN is defined.
module nap_countdown_ctrl
  import nap_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned ALARM_SEC = 10
) (
  input  logic       reset,
  input  logic       clock,
  input  logic       load,
  input  logic [3:0] set_one_sec,
  input  logic [3:0] set_ten_sec,
  input  logic [3:0] set_one_min,
  input  logic       start,
  input  logic       pause,
  input  logic       cancel,
`ifdef NAP_SNOOZE_EN
  input  logic       snooze,
`endif
  output logic [3:0] disp_one_sec,
  output logic [3:0] disp_ten_sec,
  output logic [3:0] disp_one_min,
  output logic       running,
  output logic       alarm,
  output logic       done,
  output logic       load_err
);

  localparam int unsigned ACNT_W = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;
  localparam logic [ACNT_W-1:0] ACNT_LAST = ACNT_W'(ALARM_SEC - 1);

  state_t            state;
  bcd_time_t         disp;
  bcd_time_t         setting;
  bcd_time_t         dec_next;
  logic [ACNT_W-1:0] alarm_cnt;
  logic              snooze_now;
  logic              tick;
  logic              tick_en;
  logic              tick_clr;

  assign setting  = {set_one_min, set_ten_sec, set_one_sec};
  assign dec_next = bcd_dec(disp);

`ifdef NAP_SNOOZE_EN
  assign snooze_now = snooze && (state == ALARM);
`else
  assign snooze_now = 1'b0;
`endif

  // A pause on the tick cycle freezes the prescaler at its terminal count.
  assign tick_en  = !cancel && (((state == RUN) && !pause) ||
                                ((state == ALARM) && !snooze_now));
  assign tick_clr = cancel || ((state == ARMED) && start) || snooze_now;

  nap_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clock (clock),
    .reset (reset),
    .en    (tick_en),
    .clr   (tick_clr),
    .tick  (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      disp      <= ZERO_TIME;
      alarm_cnt <= '0;
      running   <= 1'b0;
      alarm     <= 1'b0;
      done      <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      done     <= 1'b0;
      load_err <= 1'b0;
      if (cancel) begin
        state     <= IDLE;
        disp      <= ZERO_TIME;
        alarm_cnt <= '0;
        running   <= 1'b0;
        alarm     <= 1'b0;
      end else if (snooze_now) begin
        state     <= RUN;
        disp      <= SNOOZE_TIME;
        alarm_cnt <= '0;
        running   <= 1'b1;
        alarm     <= 1'b0;
      end else begin
        case (state)
          IDLE, ARMED: begin
            if ((state == ARMED) && start) begin
              state   <= RUN;
              running <= 1'b1;
            end else if (load) begin
              if (bcd_valid(setting)) begin
                disp  <= setting;
                state <= ARMED;
              end else begin
                load_err <= 1'b1;
              end
            end
          end
          RUN: begin
            if (pause) begin
              state   <= PAUSE;
              running <= 1'b0;
            end else if (tick) begin
              disp <= dec_next;
              if (dec_next == ZERO_TIME) begin
                state   <= ALARM;
                running <= 1'b0;
                alarm   <= 1'b1;
                done    <= 1'b1;
              end
            end
          end
          PAUSE: begin
            if (start) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          ALARM: begin
            if (tick) begin
              if (alarm_cnt == ACNT_LAST) begin
                state     <= IDLE;
                alarm     <= 1'b0;
                alarm_cnt <= '0;
              end else begin
                alarm_cnt <= alarm_cnt + ACNT_W'(1);
              end
            end
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
            alarm   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign disp_one_sec = disp.one_sec;
  assign disp_ten_sec = disp.ten_sec;
  assign disp_one_min = disp.one_min;

endmodule
